br_resolve_unit: RTL and testbench

- EX-stage consumer of the IF-stage branch prediction in the RV32I core.
- Carries each fetched instruction's prediction (taken flag, predicted NPC, PC) through the ID and EX slots.
- At EX, compares the prediction with the actual branch outcome and produces the redirect PC, pipeline flushes and the predictor-update strobe.
- Counts resolved branches and mispredictions for performance measurement.

---
 rtl/br_resolve_if.sv | 45 ++++
 rtl/br_resolve_unit.sv | 131 +++++++++++++
 tb/tb_br_resolve_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/br_resolve_if.sv
// Signal bundle between the pipeline/fetch side and the branch resolve unit.
// The master drives the IF/ID/EX-side inputs; the slave returns redirects, flushes and counters.
interface br_resolve_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      pc_IF;
  logic             pred_taken_IF;
  logic [31:0]      npc_pred_IF;
  logic             stall_IF;
  logic             stall_ID;
  logic             stall_EX;
  logic             flush_ID_in;
  logic             flush_EX_in;
  logic             br_inst_EX;
  logic             br_EX;
  logic [31:0]      br_target_EX;

  logic [31:0]      pc_EX;
  logic             pred_taken_EX;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_IF_ID;
  logic             flush_ID_EX;
  logic             upd_valid;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic [1:0]       dbg_state;

  // Handshake: redirect_valid has no ready. Fetch signals that it cannot
  // accept by raising stall_IF, and the unit keeps the redirect pending
  // (with flushes held) until stall_IF is low in the same cycle as redirect_valid.
  modport master (
    output pc_IF, pred_taken_IF, npc_pred_IF, stall_IF, stall_ID, stall_EX,
           flush_ID_in, flush_EX_in, br_inst_EX, br_EX, br_target_EX,
    input  pc_EX, pred_taken_EX, redirect_valid, redirect_pc, flush_IF_ID,
           flush_ID_EX, upd_valid, br_cnt, mispred_cnt, dbg_state
  );

  modport slave (
    input  pc_IF, pred_taken_IF, npc_pred_IF, stall_IF, stall_ID, stall_EX,
           flush_ID_in, flush_EX_in, br_inst_EX, br_EX, br_target_EX,
    output pc_EX, pred_taken_EX, redirect_valid, redirect_pc, flush_IF_ID,
           flush_ID_EX, upd_valid, br_cnt, mispred_cnt, dbg_state
  );
endinterface

// File: rtl/br_resolve_unit.sv
// EX-stage branch resolution: carries IF predictions through ID/EX, compares them with
// the actual outcome, issues redirects/flushes/predictor updates and counts branches.
module br_resolve_unit #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  br_resolve_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [31:0]      r_pend_pc;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mis_cnt;

  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic        r_id_pt;
  logic [31:0] r_id_npc;
  logic        r_ex_valid;
  logic [31:0] r_ex_pc;
  logic        r_ex_pt;
  logic [31:0] r_ex_npc;

  logic        w_resolve;
  logic        w_mispred;
  logic [31:0] w_correct_pc;
  logic        w_flush;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;

  // Resolve looks at the current EX contents, so it wins over a same-cycle flush_EX_in.
  always_comb begin
    w_resolve        = r_ex_valid && bus.br_inst_EX && !bus.stall_EX && (r_state != ST_SQUASH);
    w_mispred        = w_resolve && ((bus.br_EX != r_ex_pt) ||
                                     (bus.br_EX && (r_ex_npc != bus.br_target_EX)));
    w_correct_pc     = bus.br_EX ? bus.br_target_EX : (r_ex_pc + 32'd4);
    w_flush          = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_mispred) begin
          w_flush          = 1'b1;
          w_redirect_valid = !bus.stall_IF;
          w_redirect_pc    = w_correct_pc;
        end
      end
      ST_HOLD: begin
        w_flush          = 1'b1;
        w_redirect_valid = !bus.stall_IF;
        w_redirect_pc    = r_pend_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_pend_pc <= 32'd0;
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mispred) begin
            r_pend_pc <= w_correct_pc;
            r_state   <= bus.stall_IF ? ST_HOLD : ST_SQUASH;
          end
        end
        ST_HOLD:   if (!bus.stall_IF) r_state <= ST_SQUASH;
        ST_SQUASH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
      if (w_resolve && (r_br_cnt != CNT_MAX))  r_br_cnt  <= r_br_cnt + CNT_ONE;
      if (w_mispred && (r_mis_cnt != CNT_MAX)) r_mis_cnt <= r_mis_cnt + CNT_ONE;
    end
  end

  // Slot fields follow the stalls; valid is cleared by any flush, even under a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= 32'd0;
      r_id_pt    <= 1'b0;
      r_id_npc   <= 32'd0;
      r_ex_valid <= 1'b0;
      r_ex_pc    <= 32'd0;
      r_ex_pt    <= 1'b0;
      r_ex_npc   <= 32'd0;
    end else begin
      if (!bus.stall_ID) begin
        r_id_pc  <= bus.pc_IF;
        r_id_pt  <= bus.pred_taken_IF;
        r_id_npc <= bus.npc_pred_IF;
      end
      if (bus.flush_ID_in || w_flush) r_id_valid <= 1'b0;
      else if (!bus.stall_ID)         r_id_valid <= 1'b1;

      if (!bus.stall_EX) begin
        r_ex_pc  <= r_id_pc;
        r_ex_pt  <= r_id_pt;
        r_ex_npc <= r_id_npc;
      end
      if (bus.flush_EX_in || w_flush) r_ex_valid <= 1'b0;
      else if (!bus.stall_EX)         r_ex_valid <= r_id_valid;
    end
  end

  assign bus.pc_EX          = r_ex_pc;
  assign bus.pred_taken_EX  = r_ex_pt;
  assign bus.redirect_valid = w_redirect_valid;
  assign bus.redirect_pc    = w_redirect_pc;
  assign bus.flush_IF_ID    = w_flush;
  assign bus.flush_ID_EX    = w_flush;
  assign bus.upd_valid      = w_resolve;
  assign bus.br_cnt         = r_br_cnt;
  assign bus.mispred_cnt    = r_mis_cnt;
  assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Bench for br_resolve_unit: directed branch scenarios then random traffic, each cycle
// checked against a reference model through an expected-output queue.
module tb_br_resolve_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  br_resolve_if #(.CNT_W(CNT_W)) bus ();
  br_resolve_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        rst_n;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] npc;
    logic        s_if, s_id, s_ex, f_id, f_ex, bi, b;
    logic [31:0] tgt;
  } stim_t;

  typedef struct packed {
    logic             rv;
    logic [31:0]      rpc;
    logic             fl;
    logic             upd;
    logic [CNT_W-1:0] bc;
    logic [CNT_W-1:0] mc;
    logic [31:0]      pcex;
    logic             ptex;
  } exp_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] npc;
  } slot_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: mode 0 = normal, 1 = redirect waiting on fetch, 2 = quiet cycle.
  slot_t       m_id, m_ex;
  int          m_mode;
  logic [31:0] m_pend;
  int          m_br, m_mis;

  task automatic model_reset();
    m_id = '0; m_ex = '0; m_mode = 0; m_pend = 32'd0; m_br = 0; m_mis = 0;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic [31:0] pc, input logic pt, input logic [31:0] npc);
    stim_t s;
    s = '0;
    s.rst_n = 1'b1; s.pc = pc; s.pt = pt; s.npc = npc;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t        e;
    logic        res, mis, fl;
    logic [31:0] cpc;
    slot_t       nid, nex;
    @(negedge clk);
    rst               = s.rst_n;
    bus.pc_IF         = s.pc;
    bus.pred_taken_IF = s.pt;
    bus.npc_pred_IF   = s.npc;
    bus.stall_IF      = s.s_if;
    bus.stall_ID      = s.s_id;
    bus.stall_EX      = s.s_ex;
    bus.flush_ID_in   = s.f_id;
    bus.flush_EX_in   = s.f_ex;
    bus.br_inst_EX    = s.bi;
    bus.br_EX         = s.b;
    bus.br_target_EX  = s.tgt;
    if (!s.rst_n) model_reset();
    res = s.rst_n && m_ex.v && s.bi && !s.s_ex && (m_mode != 2);
    mis = res && ((s.b != m_ex.pt) || (s.b && (m_ex.npc != s.tgt)));
    cpc = s.b ? s.tgt : (m_ex.pc + 32'd4);
    e      = '0;
    e.upd  = res;
    e.bc   = CNT_W'(m_br);
    e.mc   = CNT_W'(m_mis);
    e.pcex = m_ex.pc;
    e.ptex = m_ex.pt;
    if (m_mode == 0 && mis) begin
      e.fl = 1'b1; e.rv = !s.s_if; e.rpc = cpc;
    end else if (m_mode == 1) begin
      e.fl = 1'b1; e.rv = !s.s_if; e.rpc = m_pend;
    end
    exp_q.push_back(e);
    if (s.rst_n) begin
      fl = e.fl;
      if (res && m_br < CNT_TOP) m_br++;
      if (mis && m_mis < CNT_TOP) m_mis++;
      if (m_mode == 0 && mis) begin
        m_pend = cpc;
        m_mode = s.s_if ? 1 : 2;
      end else if (m_mode == 1) begin
        m_mode = s.s_if ? 1 : 2;
      end else if (m_mode == 2) begin
        m_mode = 0;
      end
      nex = m_ex;
      if (!s.s_ex) nex = m_id;
      if (s.f_ex || fl) nex.v = 1'b0;
      nid = m_id;
      if (!s.s_id) begin
        nid.v = 1'b1; nid.pc = s.pc; nid.pt = s.pt; nid.npc = s.npc;
      end
      if (s.f_id || fl) nid.v = 1'b0;
      m_id = nid;
      m_ex = nex;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk(32'h0000_0F00 + 32'(i * 4), 1'b0, 32'd0));
  endtask

  // Feeds pc into IF, resolves it two cycles later, optionally with stall_IF held hold_cyc cycles.
  task automatic run_branch(input logic [31:0] pc, input logic pt, input logic [31:0] npc,
                            input logic b, input logic [31:0] tgt, input int hold_cyc);
    stim_t s;
    step(mk(pc, pt, npc));
    step(mk(pc + 32'd4, 1'b0, 32'd0));
    s = mk(pc + 32'd8, 1'b0, 32'd0);
    s.bi = 1'b1; s.b = b; s.tgt = tgt; s.s_if = (hold_cyc > 0);
    step(s);
    for (int i = 1; i < hold_cyc; i++) begin
      s = mk(pc + 32'd12, 1'b0, 32'd0);
      s.s_if = 1'b1;
      step(s);
    end
    idle(3);
  endtask

  task automatic chk_cnt(input string name, input int exp_b, input int exp_m);
    #3;
    cmp({name, "_br_cnt"}, 32'(bus.br_cnt), 32'(exp_b));
    cmp({name, "_mispred_cnt"}, 32'(bus.mispred_cnt), 32'(exp_m));
  endtask

  // Monitor: compares every cycle for which the driver queued an expectation.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
      if (e.rv) cmp("redirect_pc", bus.redirect_pc, e.rpc);
      cmp("flush_IF_ID", 32'(bus.flush_IF_ID), 32'(e.fl));
      cmp("flush_ID_EX", 32'(bus.flush_ID_EX), 32'(e.fl));
      cmp("upd_valid", 32'(bus.upd_valid), 32'(e.upd));
      cmp("br_cnt", 32'(bus.br_cnt), 32'(e.bc));
      cmp("mispred_cnt", 32'(bus.mispred_cnt), 32'(e.mc));
      cmp("pc_EX", bus.pc_EX, e.pcex);
      cmp("pred_taken_EX", 32'(bus.pred_taken_EX), 32'(e.ptex));
    end
  end

  initial begin
    stim_t s;
    bus.pc_IF = '0; bus.pred_taken_IF = 1'b0; bus.npc_pred_IF = '0;
    bus.stall_IF = 1'b0; bus.stall_ID = 1'b0; bus.stall_EX = 1'b0;
    bus.flush_ID_in = 1'b0; bus.flush_EX_in = 1'b0;
    bus.br_inst_EX = 1'b0; bus.br_EX = 1'b0; bus.br_target_EX = '0;
    model_reset();

    s = mk(32'd0, 1'b0, 32'd0);
    s.rst_n = 1'b0;
    repeat (3) step(s);
    idle(2);

    run_branch(32'h100, 1'b0, 32'h104, 1'b1, 32'h80, 0);
    chk_cnt("nt_vs_taken", 1, 1);
    run_branch(32'h200, 1'b1, 32'h240, 1'b1, 32'h240, 0);
    chk_cnt("correct_pred", 2, 1);
    run_branch(32'h300, 1'b1, 32'h300, 1'b1, 32'h310, 0);
    run_branch(32'h400, 1'b1, 32'h800, 1'b0, 32'h0, 0);
    chk_cnt("wrong_dir_tgt", 4, 3);
    run_branch(32'h4FC, 1'b1, 32'h600, 1'b0, 32'h0, 3);
    chk_cnt("stall_if_hold", 5, 4);

    // Second branch presented in the squash cycle must be ignored.
    step(mk(32'h700, 1'b0, 32'h704));
    step(mk(32'h704, 1'b0, 32'h708));
    s = mk(32'h708, 1'b0, 32'd0); s.bi = 1'b1; s.b = 1'b1; s.tgt = 32'h900; step(s);
    s = mk(32'h900, 1'b0, 32'd0); s.bi = 1'b1; s.b = 1'b1; s.tgt = 32'h980; step(s);
    idle(3);
    chk_cnt("back_to_back", 6, 5);

    // Reset while the redirect is pending: it must never be issued.
    step(mk(32'hA00, 1'b0, 32'hA04));
    step(mk(32'hA04, 1'b0, 32'hA08));
    s = mk(32'hA08, 1'b0, 32'd0); s.bi = 1'b1; s.b = 1'b1; s.tgt = 32'hB00; s.s_if = 1'b1; step(s);
    s = mk(32'hA08, 1'b0, 32'd0); s.s_if = 1'b1; step(s);
    s.rst_n = 1'b0; step(s); step(s);
    idle(4);
    chk_cnt("reset_in_hold", 0, 0);

    run_branch(32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 32'h0, 0);
    chk_cnt("pc_wrap", 1, 1);

    for (int i = 0; i < 17; i++)
      run_branch(32'h1000 + 32'(i * 16), 1'b0, 32'd0, 1'b1, 32'h2000, 0);
    for (int i = 0; i < 4; i++) step(mk(32'h3000 + 32'(i * 4), 1'b1, 32'h3100));
    idle(2);
    chk_cnt("saturate", CNT_TOP, CNT_TOP);

    for (int n = 0; n < 1500; n++) begin
      s       = '0;
      s.rst_n = ($urandom_range(0, 199) != 0);
      s.pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : (32'($urandom_range(0, 1023)) << 2);
      s.pt    = 1'($urandom_range(0, 1));
      s.npc   = 32'($urandom_range(0, 1023)) << 2;
      s.s_if  = ($urandom_range(0, 3) == 0);
      s.s_id  = ($urandom_range(0, 9) == 0);
      s.s_ex  = ($urandom_range(0, 9) == 0);
      s.f_id  = ($urandom_range(0, 19) == 0);
      s.f_ex  = ($urandom_range(0, 19) == 0);
      s.bi    = 1'($urandom_range(0, 1));
      s.b     = 1'($urandom_range(0, 1));
      s.tgt   = ($urandom_range(0, 1) == 1) ? m_ex.npc : (32'($urandom_range(0, 1023)) << 2);
      step(s);
    end
    idle(2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
